// File: rtl/sevenseg_pkg.sv
// Shared types and the hex-to-seven-segment glyph table for the scan controller.
package sevenseg_pkg;

  // Segment vector, bit 6 = a ... bit 0 = g
  typedef logic [6:0] seg_t;

  // All segments dark on the active-low pins
  localparam seg_t SEG_OFF_N = 7'h7F;

  // Slot phase: dark guard interval, then one anode driven
  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_state_e;

  // Active-high glyph for a hex nibble; lowercase b and d keep them distinct from 8 and 0
  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_dec.sv
// Shared hex-to-seven-segment decoder, active-high outputs, bit 6 = a.
module BCD_to_sevenSeg
  import sevenseg_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  // Pure table lookup; the caller registers and inverts the result
  always_comb begin
    seg = hex_to_seg(bcd);
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment bank.
// New values arrive through a valid/ready handshake into a shadow register and
// are copied to the displayed register only at frame boundaries.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   SLOT_BLANK | slot counter below the guard count: all anodes and segments off
//   SLOT_DRIVE | rest of the slot: anode of the current digit low, glyph driven
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] C_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] C_GUARD = CW'(GUARD_CYCLES);
  localparam logic [DW-1:0] D_LAST  = DW'(NUM_DIGITS - 1);

  logic [CW-1:0] c_q, c_next;
  logic [DW-1:0] d_q, d_next;
  logic          slot_end, boundary;

  slot_state_e   state_q, state_next;

  logic [4*NUM_DIGITS-1:0] active_val, shadow_val;
  logic [NUM_DIGITS-1:0]   active_dp, shadow_dp;
  logic                    pending, pending_next;
  logic                    xfer;
  logic                    lz_q;

  logic [3:0]            nib;
  seg_t                  seg_hi;
  logic [NUM_DIGITS-1:0] sup_mask;
  logic                  zero_run;

  logic [NUM_DIGITS-1:0] an_d;
  seg_t                  seg_d;
  logic                  dp_d;

  // Slot counter and digit index advance; the boundary is the digit wrap edge
  always_comb begin
    slot_end = (c_q == C_LAST);
    boundary = slot_end && (d_q == D_LAST);
    c_next   = slot_end ? '0 : c_q + 1'b1;
    d_next   = d_q;
    if (slot_end) begin
      d_next = (d_q == D_LAST) ? '0 : d_q + 1'b1;
    end
  end

  // Scan position registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '0;
      d_q <= '0;
    end else begin
      c_q <= c_next;
      d_q <= d_next;
    end
  end

  // Slot state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_BLANK;
    end else begin
      state_q <= state_next;
    end
  end

  // Slot state follows the region the counter is about to enter
  always_comb begin
    state_next = (c_next < C_GUARD) ? SLOT_BLANK : SLOT_DRIVE;
  end

  // Leading-zero enable is frozen for the whole drive interval of a slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lz_q <= 1'b0;
    end else if (state_q == SLOT_BLANK && state_next == SLOT_DRIVE) begin
      lz_q <= blank_lz;
    end
  end

  // Handshake: a transfer sets pending; the boundary consumes it
  always_comb begin
    xfer         = load_valid && load_ready;
    pending_next = pending;
    if (xfer) begin
      pending_next = 1'b1;
    end else if (boundary && pending) begin
      pending_next = 1'b0;
    end
  end

  // Shadow/active value registers and the registered ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      if (xfer) begin
        shadow_val <= load_data;
        shadow_dp  <= load_dp;
      end else if (boundary && pending) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
      end
      pending    <= pending_next;
      load_ready <= ~pending_next;
    end
  end

  // Select the nibble of the digit being scanned
  always_comb begin
    nib = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (d_q == DW'(i)) begin
        nib = active_val[4*i +: 4];
      end
    end
  end

  BCD_to_sevenSeg u_dec (
    .bcd (nib),
    .seg (seg_hi)
  );

  // A digit is a leading zero when it and every digit above it are zero; digit 0 never is
  always_comb begin
    zero_run = 1'b1;
    sup_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (active_val[4*i +: 4] == 4'h0);
      sup_mask[i] = zero_run;
    end
  end

  // Per-state pin values; a suppressed digit stays fully dark through its drive interval
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF_N;
    dp_d  = 1'b1;
    if (state_q == SLOT_DRIVE && !(lz_q && sup_mask[d_q])) begin
      an_d[d_q] = 1'b0;
      seg_d     = ~seg_hi;
      dp_d      = ~active_dp[d_q];
    end
  end

  // Registered pins; frame_done is looked ahead so it covers the last cycle of the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n       <= '1;
      seg_n      <= SEG_OFF_N;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an_n       <= an_d;
      seg_n      <= seg_d;
      dp_n       <= dp_d;
      frame_done <= (c_next == C_LAST) && (d_next == D_LAST);
    end
  end

endmodule
